// File: rtl/red_l1_to_int.sv
// red_l1_to_int: serial normaliser from a redundant L1 limb vector to a plain
// binary integer. One limb is resolved per clock, LSB limb first, and the carry
// is rippled into the next limb. Any carry left after the top limb means the
// value does not fit in OUT_W bits, and it is reported on ovf.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a vector; in_ready high once out of reset
// RUN   | resolving limb cnt_q, one limb per clock
// DONE  | result on dout/ovf, out_valid high until out_ready
module red_l1_to_int #(
    parameter int N_LIMB = 4,
    parameter int STRIDE = 72,
    parameter int EXT    = 4,
    parameter int OUT_W  = N_LIMB * STRIDE
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_LIMB*(STRIDE+EXT)-1:0]   din,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 dout,
    output logic                             ovf
);

    localparam int LW = STRIDE + EXT;
    localparam int SW = LW + 1;
    localparam int CW = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_LIMB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [N_LIMB*LW-1:0]      limb_q,  limb_d;
    logic [EXT:0]              carry_q, carry_d;
    logic [CW-1:0]             cnt_q,   cnt_d;
    logic [OUT_W-1:0]          dout_q,  dout_d;
    logic                      ovf_q,   ovf_d;
    // arm_q keeps in_ready low while reset is asserted and for no longer than
    // the first clock after release, without giving in_ready an input path.
    logic                      arm_q;

    logic [LW-1:0]             limb_cur;
    logic [SW-1:0]             sum;

    // Current limb plus incoming carry; the sum always fits in SW bits.
    always_comb begin
        limb_cur = limb_q[cnt_q*LW +: LW];
        sum      = SW'(limb_cur) + SW'(carry_q);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        limb_d  = limb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && arm_q) begin
                    limb_d  = din;
                    carry_d = '0;
                    cnt_d   = '0;
                    dout_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                dout_d[cnt_q*STRIDE +: STRIDE] = sum[STRIDE-1:0];
                carry_d = sum[SW-1:STRIDE];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    ovf_d   = |sum[SW-1:STRIDE];
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any vector in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            limb_q  <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            limb_q  <= limb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            arm_q   <= 1'b1;
        end
    end

    // Handshake outputs decode registered state only.
    always_comb begin
        in_ready  = (state_q == IDLE) && arm_q;
        out_valid = (state_q == DONE);
        dout      = dout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_red_l1_to_int.sv
// Directed bench for red_l1_to_int with default parameters (4 x 76-bit limbs,
// 72-bit stride, 288-bit result).
module tb_red_l1_to_int;

    localparam int N_LIMB = 4;
    localparam int STRIDE = 72;
    localparam int EXT    = 4;
    localparam int LW     = STRIDE + EXT;
    localparam int DW     = N_LIMB * LW;
    localparam int OUT_W  = N_LIMB * STRIDE;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     din;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  dout;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    red_l1_to_int #(
        .N_LIMB(N_LIMB),
        .STRIDE(STRIDE),
        .EXT(EXT),
        .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .din(din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout(dout),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pack(input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                                           input logic [LW-1:0] l2, input logic [LW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Present one vector for a single clock; caller ensures in_ready is high.
    task automatic send(input logic [DW-1:0] v);
        din      = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges from the one after the accept edge until out_valid.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit fired;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        repeat (10) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
        fired = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) fired = 1'b1;
        end
        checks++; if (fired !== 1'b0) begin errors++; $display("FAIL idle_spurious_valid got=%b exp=0", fired); end
    endtask

    task automatic test_all_ones();
        int lat;
        send(pack(76'h0_FFFF_FFFF_FFFF_FFFF_FF, 76'h0_FFFF_FFFF_FFFF_FFFF_FF,
                  76'h0_FFFF_FFFF_FFFF_FFFF_FF, 76'h0_FFFF_FFFF_FFFF_FFFF_FF));
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ones_latency got=%0d exp=4", lat); end
        checks++; if (dout !== {OUT_W{1'b1}}) begin errors++; $display("FAIL ones_dout got=%h exp=all ones", dout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ones_ovf got=%b exp=0", ovf); end
        handshake();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_valid_drop got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ones_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_carry_ripple();
        int lat;
        // 2^72 + (2^72-1)(2^72 + 2^144 + 2^216) = 2^288
        send(pack(76'h1_0000_0000_0000_0000_00, 76'h0_FFFF_FFFF_FFFF_FFFF_FF,
                  76'h0_FFFF_FFFF_FFFF_FFFF_FF, 76'h0_FFFF_FFFF_FFFF_FFFF_FF));
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL ripple_dout got=%h exp=0", dout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ripple_ovf got=%b exp=1", ovf); end
        handshake();
    endtask

    task automatic test_directed();
        logic [DW-1:0]    vec  [4];
        logic [OUT_W-1:0] expd [4];
        logic             expo [4];
        int lat;
        // ext bits only in the top limb: 15 * 2^288
        vec[0]  = pack('0, '0, '0, 76'hF_0000_0000_0000_0000_00);
        expd[0] = '0;
        expo[0] = 1'b1;
        // limb1 = 2^75 + 3 -> 3*2^72 + 2^147
        vec[1]  = pack('0, 76'h8_0000_0000_0000_0000_03, '0, '0);
        expd[1] = (288'd3 << 72) | (288'd1 << 147);
        expo[1] = 1'b0;
        // limb0 full 76 bits spills into the second 72-bit field
        vec[2]  = pack(76'hF_FFFF_FFFF_FFFF_FFFF_FF, '0, '0, '0);
        expd[2] = 288'hF_FFFF_FFFF_FFFF_FFFF_FF;
        expo[2] = 1'b0;
        // limb3 = 2^72 + 1 -> 2^288 + 2^216
        vec[3]  = pack('0, '0, '0, 76'h1_0000_0000_0000_0000_01);
        expd[3] = 288'd1 << 216;
        expo[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vec[i]);
            wait_done(lat);
            checks++; if (dout !== expd[i]) begin errors++; $display("FAIL directed%0d_dout got=%h exp=%h", i, dout, expd[i]); end
            checks++; if (ovf !== expo[i]) begin errors++; $display("FAIL directed%0d_ovf got=%b exp=%b", i, ovf, expo[i]); end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        int t[3];
        int n;
        int cyc;
        logic [OUT_W-1:0] exp_d;
        exp_d = (288'd1) | (288'd1 << 72) | (288'd1 << 144) | (288'd1 << 216);
        din       = pack(76'd1, 76'd1, 76'd1, 76'd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                t[n] = cyc;
                checks++; if (dout !== exp_d) begin errors++; $display("FAIL b2b%0d_dout got=%h exp=%h", n, dout, exp_d); end
                n++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n); end
        if (n == 3) begin
            checks++; if (t[1] - t[0] !== 6) begin errors++; $display("FAIL b2b_period1 got=%0d exp=6", t[1] - t[0]); end
            checks++; if (t[2] - t[1] !== 6) begin errors++; $display("FAIL b2b_period2 got=%0d exp=6", t[2] - t[1]); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [DW-1:0]    v;
        logic [OUT_W-1:0] exp_d;
        v     = pack(76'h123, '0, '0, 76'h1);
        exp_d = 288'h123 | (288'd1 << 216);
        send(v);
        wait_done(lat);
        for (int i = 0; i < 20; i++) begin
            din      = ~v;
            in_valid = 1'b1;
            @(negedge clk);
            checks++; if (dout !== exp_d) begin errors++; $display("FAIL bp%0d_dout got=%h exp=%h", i, dout, exp_d); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready got=%b exp=0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid got=%b exp=1", i, out_valid); end
        end
        in_valid = 1'b0;
        din      = v;
        handshake();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        checks++; if (dout !== exp_d) begin errors++; $display("FAIL bp_release_dout got=%h exp=%h", dout, exp_d); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit fired;
        send(pack(76'd7, 76'd9, 76'd11, 76'd13));
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL abort_dout got=%h exp=0", dout); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
        rstn  = 1'b1;
        fired = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) fired = 1'b1;
        end
        checks++; if (fired !== 1'b0) begin errors++; $display("FAIL abort_late_valid got=%b exp=0", fired); end
        send(pack(76'd5, '0, '0, '0));
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL after_abort_latency got=%0d exp=4", lat); end
        checks++; if (dout !== 288'd5) begin errors++; $display("FAIL after_abort_dout got=%h exp=5", dout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL after_abort_ovf got=%b exp=0", ovf); end
        handshake();
    endtask

    task automatic test_random();
        logic [LW-1:0]    l [4];
        logic [299:0]     acc;
        int lat;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) l[j] = LW'({$urandom, $urandom, $urandom});
            acc = 300'(l[0]) + (300'(l[1]) << 72) + (300'(l[2]) << 144) + (300'(l[3]) << 216);
            send(pack(l[0], l[1], l[2], l[3]));
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++; if (dout !== acc[287:0]) begin errors++; $display("FAIL rand%0d_dout got=%h exp=%h", k, dout, acc[287:0]); end
            checks++; if (ovf !== (|acc[299:288])) begin errors++; $display("FAIL rand%0d_ovf got=%b exp=%b", k, ovf, |acc[299:288]); end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_carry_ripple();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
